// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel register block: register codes, mode-bit positions,
// per-channel register record and a byte-insert helper.
// Latency: n/a (package). Backpressure: n/a.
package dma_pkg;

  localparam int MAX_ADDR_W = 16;
  localparam int MODE_W     = 6;

  // Register codes on A[3:0] for codes with A3=1.
  localparam logic [3:0] REG_CMD     = 4'b1000;  // write: command
  localparam logic [3:0] REG_STATUS  = 4'b1000;  // read: status {4'b0, TC}
  localparam logic [3:0] REG_MODE    = 4'b1011;
  localparam logic [3:0] REG_CLR_PTR = 4'b1100;
  localparam logic [3:0] REG_MCLR    = 4'b1101;

  // Bit positions inside the written mode byte. Only byte bits [7:2] are stored,
  // so the stored index is the byte position minus MODE_LSB.
  localparam int MODE_LSB      = 2;
  localparam int MODE_AUTO_BIT = 4;
  localparam int MODE_DEC_BIT  = 5;

  // Per-channel storage, always held at the maximum width; bits above ADDR_W stay zero.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] base_addr;
    logic [MAX_ADDR_W-1:0] cur_addr;
    logic [MAX_ADDR_W-1:0] base_cnt;
    logic [MAX_ADDR_W-1:0] cur_cnt;
  } ch_regs_t;

  // Insert one byte (low or high) into a register and drop bits outside mask.
  function automatic logic [MAX_ADDR_W-1:0] put_byte(
    input logic [MAX_ADDR_W-1:0] old,
    input logic                  hi,
    input logic [7:0]            b,
    input logic [MAX_ADDR_W-1:0] mask
  );
    logic [MAX_ADDR_W-1:0] v;
    v = hi ? {b, old[7:0]} : {old[15:8], b};
    return v & mask;
  endfunction

endpackage

// File: rtl/dma_channel_regs_if.sv
// Host register bus of the DMA channel block: chip select, strobes, address code, data bytes.
// Latency: n/a (wiring only). Backpressure: none, strobe-driven bus.
// Ports: CS_N/IOR_N/IOW_N/A/DB_IN from host; DB_OUT/DB_OE back to host.
interface dma_channel_regs_if;
  logic       CS_N;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;

  modport master (output CS_N, IOR_N, IOW_N, A, DB_IN, input DB_OUT, DB_OE);
  modport slave  (input CS_N, IOR_N, IOW_N, A, DB_IN, output DB_OUT, DB_OE);
endinterface

// File: rtl/dma_channel_slice.sv
// One DMA channel: base/current address and word count, byte programming and transfer update.
// Latency: state changes on the edge after wr_en/upd_en; tc_evt is combinational. Backpressure: none.
// Ports: clk, rst (sync), wr_* byte write, upd_* update request with mode bits, cur_* and tc_evt out.
module dma_channel_slice
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_cnt,   // 1: word count, 0: address
  input  logic                  wr_hi,    // byte pointer
  input  logic [7:0]            wr_dat,
  input  logic                  upd_en,
  input  logic                  upd_dec,
  input  logic                  upd_auto,
  output logic [MAX_ADDR_W-1:0] cur_addr,
  output logic [MAX_ADDR_W-1:0] cur_cnt,
  output logic                  tc_evt
);

  localparam logic [MAX_ADDR_W-1:0] W_MASK = MAX_ADDR_W'((32'd1 << ADDR_W) - 32'd1);

  ch_regs_t              regs_q, regs_d;
  logic [MAX_ADDR_W-1:0] addr_step;

  // Address steps wrap within ADDR_W bits in either direction.
  assign addr_step = regs_q.cur_addr + (upd_dec ? W_MASK : MAX_ADDR_W'(1));

  always_comb begin
    regs_d = regs_q;
    tc_evt = 1'b0;
    // Programming takes priority; a coincident update is simply lost.
    if (wr_en) begin
      if (wr_cnt) begin
        regs_d.base_cnt = put_byte(regs_q.base_cnt, wr_hi, wr_dat, W_MASK);
        regs_d.cur_cnt  = put_byte(regs_q.cur_cnt,  wr_hi, wr_dat, W_MASK);
      end else begin
        regs_d.base_addr = put_byte(regs_q.base_addr, wr_hi, wr_dat, W_MASK);
        regs_d.cur_addr  = put_byte(regs_q.cur_addr,  wr_hi, wr_dat, W_MASK);
      end
    end else if (upd_en) begin
      if (regs_q.cur_cnt == '0) begin
        tc_evt = 1'b1;
        if (upd_auto) begin
          regs_d.cur_addr = regs_q.base_addr;
          regs_d.cur_cnt  = regs_q.base_cnt;
        end else begin
          regs_d.cur_addr = addr_step & W_MASK;
          regs_d.cur_cnt  = W_MASK;
        end
      end else begin
        regs_d.cur_addr = addr_step & W_MASK;
        regs_d.cur_cnt  = (regs_q.cur_cnt - MAX_ADDR_W'(1)) & W_MASK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign cur_addr = regs_q.cur_addr;
  assign cur_cnt  = regs_q.cur_cnt;

endmodule

// File: rtl/dma_channel_regs.sv
// DMA channel register file: host byte access to address/count/mode/command/status plus transfer updates.
// Latency: writes land on the recognition edge; read data and TC_PULSE appear the cycle after. Backpressure: none.
// Ports: CLK, RESET (sync high), bus (host), UPD_VALID/UPD_CH, CUR_ADDR, MODE, CMD, TC_PULSE.
module dma_channel_regs
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  dma_channel_regs_if.slave        bus,
  input  logic                     UPD_VALID,
  input  logic [1:0]               UPD_CH,
  output logic [NUM_CH*ADDR_W-1:0] CUR_ADDR,
  output logic [NUM_CH*MODE_W-1:0] MODE,
  output logic [7:0]               CMD,
  output logic [NUM_CH-1:0]        TC_PULSE
);

  logic                                acc_prev_q, acc_prev_d;
  logic                                ptr_q, ptr_d;
  logic [7:0]                          cmd_q, cmd_d;
  logic [NUM_CH-1:0][MODE_W-1:0]       mode_q, mode_d;
  logic [NUM_CH-1:0]                   tc_q, tc_d;
  logic [NUM_CH-1:0]                   tc_pulse_q, tc_pulse_d;
  logic [7:0]                          db_out_q, db_out_d;
  logic                                rd_act_q, rd_act_d;

  logic                                acc_cond, acc_go, rd_go, wr_go;
  logic                                chan_acc, mclr, slice_rst;
  logic [1:0]                          sel_ch;
  logic [NUM_CH-1:0][MAX_ADDR_W-1:0]   cur_addr_w, cur_cnt_w;
  logic [NUM_CH-1:0]                   tc_evt;
  logic [MAX_ADDR_W-1:0]               rd_word;
  logic [7:0]                          rd_byte;
  logic [3:0]                          status;

  // An access starts on the first cycle of a clean single-strobe select. acc_prev_q
  // powers up set, so a strobe held through reset is ignored until it is released.
  assign acc_cond  = !bus.CS_N && (bus.IOR_N != bus.IOW_N);
  assign acc_go    = acc_cond && !acc_prev_q;
  assign rd_go     = acc_go && !bus.IOR_N;
  assign wr_go     = acc_go && !bus.IOW_N;
  assign chan_acc  = !bus.A[3];
  assign sel_ch    = bus.A[2:1];
  assign mclr      = wr_go && (bus.A == REG_MCLR);
  assign slice_rst = RESET || mclr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_channel_slice #(.ADDR_W(ADDR_W)) u_slice (
      .clk      (CLK),
      .rst      (slice_rst),
      .wr_en    (wr_go && chan_acc && (sel_ch == 2'(g))),
      .wr_cnt   (bus.A[0]),
      .wr_hi    (ptr_q),
      .wr_dat   (bus.DB_IN),
      .upd_en   (UPD_VALID && (UPD_CH == 2'(g))),
      .upd_dec  (mode_q[g][MODE_DEC_BIT-MODE_LSB]),
      .upd_auto (mode_q[g][MODE_AUTO_BIT-MODE_LSB]),
      .cur_addr (cur_addr_w[g]),
      .cur_cnt  (cur_cnt_w[g]),
      .tc_evt   (tc_evt[g])
    );
    assign CUR_ADDR[g*ADDR_W +: ADDR_W] = cur_addr_w[g][ADDR_W-1:0];
  end

  // Read data selection; unimplemented channels and codes fall through to 8'h00.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch == 2'(i)) rd_word = bus.A[0] ? cur_cnt_w[i] : cur_addr_w[i];
    end
    status = '0;
    status[NUM_CH-1:0] = tc_q;
    rd_byte = 8'h00;
    if (chan_acc)                  rd_byte = ptr_q ? rd_word[15:8] : rd_word[7:0];
    else if (bus.A == REG_STATUS)  rd_byte = {4'b0000, status};
  end

  always_comb begin
    acc_prev_d = acc_cond;
    ptr_d      = ptr_q;
    cmd_d      = cmd_q;
    mode_d     = mode_q;
    tc_pulse_d = tc_evt;
    db_out_d   = rd_go ? rd_byte : db_out_q;
    rd_act_d   = rd_go || (rd_act_q && !bus.CS_N && !bus.IOR_N);

    if (acc_go && chan_acc) ptr_d = !ptr_q;
    if (wr_go && (bus.A == REG_CLR_PTR)) ptr_d = 1'b0;
    if (wr_go && (bus.A == REG_CMD)) cmd_d = bus.DB_IN;
    if (wr_go && (bus.A == REG_MODE)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.DB_IN[1:0] == 2'(i)) mode_d[i] = bus.DB_IN[7:2];
      end
    end

    // Status read clears old flags, but a terminal count in the same cycle survives.
    tc_d = ((rd_go && (bus.A == REG_STATUS)) ? '0 : tc_q) | tc_evt;

    if (mclr) begin
      acc_prev_d = 1'b1;
      ptr_d      = 1'b0;
      cmd_d      = '0;
      mode_d     = '0;
      tc_d       = '0;
      tc_pulse_d = '0;
      db_out_d   = '0;
      rd_act_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_prev_q <= 1'b1;
      ptr_q      <= 1'b0;
      cmd_q      <= '0;
      mode_q     <= '0;
      tc_q       <= '0;
      tc_pulse_q <= '0;
      db_out_q   <= '0;
      rd_act_q   <= 1'b0;
    end else begin
      acc_prev_q <= acc_prev_d;
      ptr_q      <= ptr_d;
      cmd_q      <= cmd_d;
      mode_q     <= mode_d;
      tc_q       <= tc_d;
      tc_pulse_q <= tc_pulse_d;
      db_out_q   <= db_out_d;
      rd_act_q   <= rd_act_d;
    end
  end

  assign MODE       = mode_q;
  assign CMD        = cmd_q;
  assign TC_PULSE   = tc_pulse_q;
  assign bus.DB_OUT = db_out_q;
  assign bus.DB_OE  = rd_act_q && !bus.CS_N && !bus.IOR_N;

endmodule

// File: tb/tb_dma_channel_regs.sv
// Bench for dma_channel_regs: directed cases plus random traffic against a behavioural model.
// Latency: n/a. Backpressure: n/a.
// Two instances: 4 channels x 16 bits (modelled) and 2 channels x 9 bits (boundary cases).
module tb_dma_channel_regs;
  import dma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        upd_vld, upd1_vld;
  logic [1:0]  upd_ch, upd1_ch;
  logic [63:0] cur_addr0;
  logic [23:0] mode0;
  logic [7:0]  cmd0;
  logic [3:0]  tcp0;
  logic [17:0] cur_addr1;
  logic [11:0] mode1;
  logic [7:0]  cmd1;
  logic [1:0]  tcp1;

  dma_channel_regs_if bus0();
  dma_channel_regs_if bus1();

  dma_channel_regs #(.NUM_CH(4), .ADDR_W(16)) dut0 (
    .CLK(clk), .RESET(rst), .bus(bus0), .UPD_VALID(upd_vld), .UPD_CH(upd_ch),
    .CUR_ADDR(cur_addr0), .MODE(mode0), .CMD(cmd0), .TC_PULSE(tcp0));

  dma_channel_regs #(.NUM_CH(2), .ADDR_W(9)) dut1 (
    .CLK(clk), .RESET(rst), .bus(bus1), .UPD_VALID(upd1_vld), .UPD_CH(upd1_ch),
    .CUR_ADDR(cur_addr1), .MODE(mode1), .CMD(cmd1), .TC_PULSE(tcp1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the 4-channel, 16-bit instance.
  localparam int unsigned MASK0 = 32'hFFFF;
  int unsigned m_ba[4], m_ca[4], m_bc[4], m_cc[4];
  logic [7:0]  m_mode[4];  // mode byte as written, channel bits cleared
  logic [7:0]  m_cmd;
  logic [3:0]  m_tc;
  bit          m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ba[i] = 0; m_ca[i] = 0; m_bc[i] = 0; m_cc[i] = 0; m_mode[i] = 8'h00;
    end
    m_cmd = 8'h00; m_tc = 4'h0; m_ptr = 1'b0;
  endfunction

  function automatic int unsigned put_b(input int unsigned old, input logic [7:0] d);
    if (m_ptr) return ((old & 32'h00FF) | (32'(d) << 8)) & MASK0;
    return ((old & 32'hFF00) | 32'(d)) & MASK0;
  endfunction

  function automatic void model_wr(input logic [3:0] a, input logic [7:0] d);
    int ch;
    if (!a[3]) begin
      ch = int'(a[2:1]);
      if (a[0]) begin m_bc[ch] = put_b(m_bc[ch], d); m_cc[ch] = put_b(m_cc[ch], d); end
      else      begin m_ba[ch] = put_b(m_ba[ch], d); m_ca[ch] = put_b(m_ca[ch], d); end
      m_ptr = !m_ptr;
    end else if (a == 4'b1000) m_cmd = d;
    else if (a == 4'b1011) m_mode[int'(d[1:0])] = d & 8'hFC;
    else if (a == 4'b1100) m_ptr = 1'b0;
    else if (a == 4'b1101) model_reset();
  endfunction

  function automatic logic [7:0] model_rd(input logic [3:0] a);
    int unsigned v;
    logic [7:0]  r;
    r = 8'h00;
    if (!a[3]) begin
      v = a[0] ? m_cc[int'(a[2:1])] : m_ca[int'(a[2:1])];
      r = m_ptr ? 8'(v >> 8) : 8'(v);
      m_ptr = !m_ptr;
    end else if (a == 4'b1000) begin
      r = {4'h0, m_tc};
      m_tc = 4'h0;
    end
    return r;
  endfunction

  function automatic bit model_upd(input int ch);
    int unsigned nxt;
    nxt = m_mode[ch][5] ? (m_ca[ch] + MASK0) & MASK0 : (m_ca[ch] + 1) & MASK0;
    if (m_cc[ch] == 0) begin
      m_tc[ch] = 1'b1;
      if (m_mode[ch][4]) begin m_ca[ch] = m_ba[ch]; m_cc[ch] = m_bc[ch]; end
      else               begin m_ca[ch] = nxt;      m_cc[ch] = MASK0;    end
      return 1'b1;
    end
    m_ca[ch] = nxt;
    m_cc[ch] = m_cc[ch] - 1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic cs_n, input logic ior_n, input logic iow_n,
                       input logic [3:0] a, input logic [7:0] d);
    if (which == 0) begin
      bus0.CS_N = cs_n; bus0.IOR_N = ior_n; bus0.IOW_N = iow_n; bus0.A = a; bus0.DB_IN = d;
    end else begin
      bus1.CS_N = cs_n; bus1.IOR_N = ior_n; bus1.IOW_N = iow_n; bus1.A = a; bus1.DB_IN = d;
    end
  endtask

  task automatic bus_wr(input int which, input logic [3:0] a, input logic [7:0] d);
    drive(which, 1'b0, 1'b1, 1'b0, a, d);
    tick();
    upd_vld = 1'b0;
    drive(which, 1'b1, 1'b1, 1'b1, a, d);
    tick();
    if (which == 0) model_wr(a, d);
  endtask

  task automatic bus_rd(input int which, input logic [3:0] a, output logic [7:0] d);
    drive(which, 1'b0, 1'b0, 1'b1, a, 8'h00);
    tick();
    d = (which == 0) ? bus0.DB_OUT : bus1.DB_OUT;
    chk("db_oe_on", (which == 0) ? bus0.DB_OE : bus1.DB_OE, 1'b1);
    drive(which, 1'b1, 1'b1, 1'b1, a, 8'h00);
    tick();
    chk("db_oe_off", (which == 0) ? bus0.DB_OE : bus1.DB_OE, 1'b0);
  endtask

  task automatic rd0(input logic [3:0] a, input string tag, output logic [7:0] d);
    logic [7:0] e;
    bus_rd(0, a, d);
    e = model_rd(a);
    chk(tag, d, e);
  endtask

  task automatic check_state(input string tag);
    logic [63:0] ea;
    logic [23:0] em;
    for (int i = 0; i < 4; i++) begin
      ea[i*16 +: 16] = 16'(m_ca[i]);
      em[i*6 +: 6]   = m_mode[i][7:2];
    end
    chk({tag, ".addr"}, cur_addr0, ea);
    chk({tag, ".mode"}, mode0, em);
    chk({tag, ".cmd"}, cmd0, m_cmd);
  endtask

  task automatic upd0(input int ch, input string tag);
    bit p;
    upd_vld = 1'b1;
    upd_ch  = 2'(ch);
    tick();
    upd_vld = 1'b0;
    p = model_upd(ch);
    chk(tag, tcp0, p ? (4'b0001 << ch) : 4'b0000);
    check_state(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [3:0]  a;
    int          op, ch;

    rst = 1'b1; upd_vld = 1'b0; upd_ch = 2'd0; upd1_vld = 1'b0; upd1_ch = 2'd0;
    drive(0, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00);
    drive(1, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_state("reset");
    chk("reset.tcp", tcp0, 4'h0);
    chk("reset.db_out", bus0.DB_OUT, 8'h00);
    chk("reset.db_oe", bus0.DB_OE, 1'b0);
    chk("reset.addr1", cur_addr1, 18'h0);

    // Channel 1 address in two bytes, read back low then high
    bus_wr(0, 4'b0010, 8'h34);
    bus_wr(0, 4'b0010, 8'h12);
    chk("ch1_addr", cur_addr0[31:16], 16'h1234);
    rd0(4'b0010, "ch1_rd_lo", d); chk("ch1_lo_const", d, 8'h34);
    rd0(4'b0010, "ch1_rd_hi", d); chk("ch1_hi_const", d, 8'h12);

    // Byte pointer clear between bytes
    bus_wr(0, 4'b0000, 8'h99);
    bus_wr(0, 4'b1100, 8'h00);
    bus_wr(0, 4'b0001, 8'h56);
    bus_wr(0, 4'b0001, 8'h78);
    rd0(4'b0001, "ch0_cnt_lo", d); chk("ch0_cnt_lo_const", d, 8'h56);
    rd0(4'b0001, "ch0_cnt_hi", d); chk("ch0_cnt_hi_const", d, 8'h78);

    // Autoinit on channel 2: count 1, base address 100h
    bus_wr(0, 4'b1011, 8'h12);
    bus_wr(0, 4'b0100, 8'h00);
    bus_wr(0, 4'b0100, 8'h01);
    bus_wr(0, 4'b0101, 8'h01);
    bus_wr(0, 4'b0101, 8'h00);
    upd0(2, "ai_upd1");
    upd0(2, "ai_upd2");
    chk("ai_tcp_const", tcp0, 4'b0100);
    chk("ai_addr_const", cur_addr0[47:32], 16'h0100);
    tick();
    chk("ai_tcp_clear", tcp0, 4'h0);
    rd0(4'b0101, "ai_cnt_lo", d); chk("ai_cnt_lo_const", d, 8'h01);
    rd0(4'b0101, "ai_cnt_hi", d);
    rd0(4'b1000, "ai_status1", d); chk("ai_status1_const", d, 8'h04);
    rd0(4'b1000, "ai_status2", d); chk("ai_status2_const", d, 8'h00);
    upd0(2, "ai_upd3");

    // Decrement mode wraps 0000h to FFFFh
    bus_wr(0, 4'b1011, 8'h20);
    bus_wr(0, 4'b0000, 8'h00);
    bus_wr(0, 4'b0000, 8'h00);
    upd0(0, "dec_upd");
    chk("dec_addr_const", cur_addr0[15:0], 16'hFFFF);

    // Programming write beats a same-cycle update of that channel (count 0, would hit TC)
    upd_vld = 1'b1; upd_ch = 2'd3;
    bus_wr(0, 4'b0110, 8'hAA);
    check_state("coll");
    chk("coll_addr_const", cur_addr0[63:48], 16'h00AA);
    rd0(4'b1000, "coll_status", d); chk("coll_status_const", d, 8'h00);
    bus_wr(0, 4'b1100, 8'h00);

    // Both strobes low is not an access
    drive(0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'hEE);
    tick();
    drive(0, 1'b1, 1'b1, 1'b1, 4'b0000, 8'h00);
    tick();
    check_state("both_low");
    rd0(4'b0000, "both_low_rd", d); chk("both_low_rd_const", d, 8'hFF);

    // Small instance: channel 3 does not exist, 9-bit registers
    bus_wr(1, 4'b0110, 8'h5A);
    chk("nc_wr_ignored", cur_addr1, 18'h0);
    bus_wr(1, 4'b0000, 8'hAB);
    chk("nc_ptr_toggled", cur_addr1, 18'h00100);
    bus_rd(1, 4'b0110, d); chk("nc_rd_zero", d, 8'h00);
    bus_rd(1, 4'b0000, d); chk("nc_rd_hi", d, 8'h01);
    bus_wr(1, 4'b1011, 8'h23);
    chk("nc_mode_ignored", mode1, 12'h0);
    upd1_vld = 1'b1; upd1_ch = 2'd3; tick(); upd1_vld = 1'b0;
    chk("nc_upd_tcp", tcp1, 2'b00);
    chk("nc_upd_addr", cur_addr1, 18'h00100);
    upd1_vld = 1'b1; upd1_ch = 2'd0; tick(); upd1_vld = 1'b0;
    chk("w9_upd_tcp", tcp1, 2'b01);
    chk("w9_upd_addr", cur_addr1, 18'h00101);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, 3));
      if (op <= 2) begin
        a = {1'b0, 2'(ch), 1'($urandom_range(0, 1))};
        d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom);
        bus_wr(0, a, d);
        check_state("rnd_wr");
      end else if (op <= 4) begin
        a = {1'b0, 2'(ch), 1'($urandom_range(0, 1))};
        rd0(a, "rnd_rd", d);
      end else if (op == 5) begin
        a = ($urandom_range(0, 1) == 1) ? 4'b1000 : 4'($urandom_range(9, 15));
        rd0(a, "rnd_rd_hi", d);
      end else if (op == 6) begin
        bus_wr(0, 4'b1011, 8'($urandom));
        check_state("rnd_mode");
      end else if (op == 7) begin
        bus_wr(0, 4'b1000, 8'($urandom));
        check_state("rnd_cmd");
      end else if (op == 8) begin
        upd0(ch, "rnd_upd");
      end else begin
        bus_wr(0, 4'b1100, 8'h00);
      end
    end

    // Master clear
    bus_wr(0, 4'b1101, 8'h00);
    check_state("mclr");
    rd0(4'b0010, "mclr_rd", d); chk("mclr_rd_const", d, 8'h00);
    rd0(4'b1000, "mclr_status", d);

    // Reset with IOW_N held low, then only a fresh strobe commits
    bus_wr(0, 4'b0000, 8'h77);
    rd0(4'b0000, "pre_rst_rd", d);
    drive(0, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h55);
    rst = 1'b1;
    tick(); tick();
    model_reset();
    check_state("rst_hold");
    chk("rst_hold.tcp", tcp0, 4'h0);
    chk("rst_hold.db_out", bus0.DB_OUT, 8'h00);
    chk("rst_hold.db_oe", bus0.DB_OE, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_no_commit", cur_addr0, 64'h0);
    drive(0, 1'b1, 1'b1, 1'b1, 4'b0000, 8'h00);
    tick();
    bus_wr(0, 4'b0000, 8'h55);
    chk("rst_fresh_commit", cur_addr0[15:0], 16'h0055);
    check_state("rst_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
